// File: rtl/vm2002_change_dispenser.sv
// vm2002 outbound coin path: pays change greedily, one coin per hopper handshake,
// and keeps per-denomination hopper inventory.

package vm2002_common_pkg;
    typedef enum logic [1:0] {
        NO_COINS = 2'd0,
        NICKEL   = 2'd1,
        DIME     = 2'd2,
        QUARTER  = 2'd3
    } coins_t;
endpackage

module vm2002_change_dispenser
    import vm2002_common_pkg::*;
#(
    parameter int unsigned AMT_W         = 8,
    parameter int unsigned CNT_W         = 6,
    parameter int unsigned INIT_QUARTERS = 20,
    parameter int unsigned INIT_DIMES    = 20,
    parameter int unsigned INIT_NICKELS  = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amount,
    output logic             change_ready,
    output logic [1:0]       coin_out,
    output logic             coin_valid,
    input  logic             coin_ack,
    input  logic             restock,
    input  logic [CNT_W-1:0] restock_quarters,
    input  logic [CNT_W-1:0] restock_dimes,
    input  logic [CNT_W-1:0] restock_nickels,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] quarter_cnt,
    output logic [CNT_W-1:0] dime_cnt,
    output logic [CNT_W-1:0] nickel_cnt
);

    localparam logic [AMT_W-1:0] VAL_QUARTER = AMT_W'(25);
    localparam logic [AMT_W-1:0] VAL_DIME    = AMT_W'(10);
    localparam logic [AMT_W-1:0] VAL_NICKEL  = AMT_W'(5);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] q_cnt_q, q_cnt_d, d_cnt_q, d_cnt_d, n_cnt_q, n_cnt_d;
    coins_t           coin_q, coin_d;
    logic             coin_valid_q, coin_valid_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             short_q, short_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;

    // Saturating inventory add; the carry bit flags overflow.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    function automatic logic [AMT_W-1:0] coin_value(input coins_t c);
        case (c)
            QUARTER: return VAL_QUARTER;
            DIME:    return VAL_DIME;
            NICKEL:  return VAL_NICKEL;
            default: return '0;
        endcase
    endfunction

    // Next-state and output computation.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        q_cnt_d      = q_cnt_q;
        d_cnt_d      = d_cnt_q;
        n_cnt_d      = n_cnt_q;
        coin_d       = coin_q;
        coin_valid_d = coin_valid_q;
        done_d       = 1'b0;
        short_d      = short_q;
        remaining_d  = remaining_q;

        case (state_q)
            IDLE: begin
                if (restock) begin
                    q_cnt_d = sat_add(q_cnt_q, restock_quarters);
                    d_cnt_d = sat_add(d_cnt_q, restock_dimes);
                    n_cnt_d = sat_add(n_cnt_q, restock_nickels);
                end
                if (change_valid) begin
                    rem_d       = change_amount;
                    short_d     = 1'b0;
                    remaining_d = '0;
                    state_d     = SELECT;
                end
            end
            SELECT: begin
                if (rem_q >= VAL_QUARTER && q_cnt_q != '0) begin
                    coin_d       = QUARTER;
                    coin_valid_d = 1'b1;
                    state_d      = ISSUE;
                end else if (rem_q >= VAL_DIME && d_cnt_q != '0) begin
                    coin_d       = DIME;
                    coin_valid_d = 1'b1;
                    state_d      = ISSUE;
                end else if (rem_q >= VAL_NICKEL && n_cnt_q != '0) begin
                    coin_d       = NICKEL;
                    coin_valid_d = 1'b1;
                    state_d      = ISSUE;
                end else begin
                    done_d      = 1'b1;
                    short_d     = (rem_q != '0);
                    remaining_d = rem_q;
                    state_d     = DONE;
                end
            end
            ISSUE: begin
                if (coin_ack) begin
                    rem_d = rem_q - coin_value(coin_q);
                    case (coin_q)
                        QUARTER: q_cnt_d = q_cnt_q - CNT_W'(1);
                        DIME:    d_cnt_d = d_cnt_q - CNT_W'(1);
                        NICKEL:  n_cnt_d = n_cnt_q - CNT_W'(1);
                        default: ;
                    endcase
                    coin_d       = NO_COINS;
                    coin_valid_d = 1'b0;
                    state_d      = SELECT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            q_cnt_q      <= CNT_W'(INIT_QUARTERS);
            d_cnt_q      <= CNT_W'(INIT_DIMES);
            n_cnt_q      <= CNT_W'(INIT_NICKELS);
            coin_q       <= NO_COINS;
            coin_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            remaining_q  <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            q_cnt_q      <= q_cnt_d;
            d_cnt_q      <= d_cnt_d;
            n_cnt_q      <= n_cnt_d;
            coin_q       <= coin_d;
            coin_valid_q <= coin_valid_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            short_q      <= short_d;
            remaining_q  <= remaining_d;
        end
    end

    assign change_ready = ready_q;
    assign coin_out     = coin_q;
    assign coin_valid   = coin_valid_q;
    assign done         = done_q;
    assign short        = short_q;
    assign remaining    = remaining_q;
    assign quarter_cnt  = q_cnt_q;
    assign dime_cnt     = d_cnt_q;
    assign nickel_cnt   = n_cnt_q;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Scoreboard bench for vm2002_change_dispenser: requests and restocks are issued
// against an arithmetic inventory model; a monitor checks coins and completions.

module tb_vm2002_change_dispenser;
    import vm2002_common_pkg::*;

    localparam int unsigned AMT_W   = 8;
    localparam int unsigned CNT_W   = 6;
    localparam int          CNT_MAX = 63;
    localparam int          INIT_N  = 20;

    logic             clk = 1'b0;
    logic             reset;
    logic             change_valid;
    logic [AMT_W-1:0] change_amount;
    logic             change_ready;
    logic [1:0]       coin_out;
    logic             coin_valid;
    logic             coin_ack;
    logic             restock;
    logic [CNT_W-1:0] restock_quarters, restock_dimes, restock_nickels;
    logic             done, short;
    logic [AMT_W-1:0] remaining;
    logic [CNT_W-1:0] quarter_cnt, dime_cnt, nickel_cnt;

    vm2002_change_dispenser dut (
        .clk(clk), .reset(reset),
        .change_valid(change_valid), .change_amount(change_amount),
        .change_ready(change_ready),
        .coin_out(coin_out), .coin_valid(coin_valid), .coin_ack(coin_ack),
        .restock(restock), .restock_quarters(restock_quarters),
        .restock_dimes(restock_dimes), .restock_nickels(restock_nickels),
        .done(done), .short(short), .remaining(remaining),
        .quarter_cnt(quarter_cnt), .dime_cnt(dime_cnt), .nickel_cnt(nickel_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit sh;
        int rem;
        int q;
        int d;
        int n;
    } res_t;

    int   coin_q[$];
    res_t res_q[$];
    int   mq, md, mn;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    bit   busy_rs = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int a, input int b);
        return (a + b > CNT_MAX) ? CNT_MAX : a + b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Greedy payout model: as many of each coin as value and stock allow, largest first.
    task automatic model_pay(input int amt);
        int k;
        res_t r;
        k = imin(amt / 25, mq); mq -= k; amt -= 25 * k;
        repeat (k) coin_q.push_back(int'(QUARTER));
        k = imin(amt / 10, md); md -= k; amt -= 10 * k;
        repeat (k) coin_q.push_back(int'(DIME));
        k = imin(amt / 5, mn);  mn -= k; amt -= 5 * k;
        repeat (k) coin_q.push_back(int'(NICKEL));
        r.sh = (amt != 0); r.rem = amt; r.q = mq; r.d = md; r.n = mn;
        res_q.push_back(r);
    endtask

    // Called #1 after a rising edge with change_ready observed high.
    task automatic do_request(input int amt, input bit rs, input int rq, input int rd, input int rn);
        if (rs) begin
            restock = 1'b1;
            restock_quarters = CNT_W'(rq);
            restock_dimes    = CNT_W'(rd);
            restock_nickels  = CNT_W'(rn);
            mq = sat(mq, rq); md = sat(md, rd); mn = sat(mn, rn);
        end
        change_valid  = 1'b1;
        change_amount = AMT_W'(amt);
        model_pay(amt);
        @(posedge clk); #1;
        change_valid = 1'b0;
        restock = 1'b0;
    endtask

    // Wait for idle; optionally poke restock while busy (must be ignored).
    task automatic wait_ready();
        for (int i = 0; i < 3000; i++) begin
            if (change_ready) return;
            if (busy_rs && $urandom_range(0, 3) == 0) begin
                restock = 1'b1;
                restock_quarters = CNT_W'($urandom_range(0, 63));
                restock_dimes    = CNT_W'($urandom_range(0, 63));
                restock_nickels  = CNT_W'($urandom_range(0, 63));
            end
            @(posedge clk); #1;
            restock = 1'b0;
        end
        check("ready_timeout", 0, 1);
    endtask

    // Hopper: acks offered coins after a random delay, with occasional stray acks.
    initial begin
        coin_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (coin_valid) coin_ack = ($urandom_range(0, 2) == 0);
            else            coin_ack = ($urandom_range(0, 7) == 0);
        end
    end

    logic       prev_valid = 1'b0;
    logic       prev_ack = 1'b0;
    logic [1:0] prev_coin = 2'd0;

    // Monitor: pops expected coins and completions as the DUT presents them.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (coin_valid && prev_valid && !prev_ack) begin
                check("coin_hold", int'(coin_out), int'(prev_coin));
            end else if (coin_valid) begin
                if (coin_q.size() == 0) check("unexpected_coin", int'(coin_out), int'(NO_COINS));
                else check("coin_out", int'(coin_out), coin_q.pop_front());
            end else begin
                check("idle_coin_out", int'(coin_out), int'(NO_COINS));
            end
            if (done) begin
                check("coins_left", coin_q.size(), 0);
                if (res_q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("short", int'(short), int'(r.sh));
                    check("remaining", int'(remaining), r.rem);
                    check("quarter_cnt", int'(quarter_cnt), r.q);
                    check("dime_cnt", int'(dime_cnt), r.d);
                    check("nickel_cnt", int'(nickel_cnt), r.n);
                end
            end
        end
        prev_valid = coin_valid;
        prev_ack   = coin_ack;
        prev_coin  = coin_out;
    end

    initial begin
        reset = 1'b1;
        change_valid = 1'b0;
        change_amount = '0;
        restock = 1'b0;
        restock_quarters = '0;
        restock_dimes = '0;
        restock_nickels = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(change_ready), 1);
        check("rst_coin_valid", int'(coin_valid), 0);
        check("rst_coin_out", int'(coin_out), int'(NO_COINS));
        check("rst_done", int'(done), 0);
        check("rst_short", int'(short), 0);
        check("rst_remaining", int'(remaining), 0);
        check("rst_quarters", int'(quarter_cnt), INIT_N);
        check("rst_dimes", int'(dime_cnt), INIT_N);
        check("rst_nickels", int'(nickel_cnt), INIT_N);
        mq = INIT_N; md = INIT_N; mn = INIT_N;
        reset = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // 65 -> Q,Q,D,N; then zero and odd amounts.
        wait_ready(); do_request(65, 0, 0, 0, 0);
        wait_ready(); do_request(0, 0, 0, 0, 0);
        wait_ready(); do_request(7, 0, 0, 0, 0);

        // Saturating restock in idle.
        wait_ready();
        restock = 1'b1;
        restock_quarters = '0; restock_dimes = CNT_W'(63); restock_nickels = '0;
        md = sat(md, 63);
        @(posedge clk); #1;
        restock = 1'b0;
        check("dime_sat", int'(dime_cnt), CNT_MAX);

        // Drain inventory with no restocks so shortfalls show up.
        for (int i = 0; i < 40; i++) begin
            wait_ready();
            do_request($urandom_range(0, 255), 0, 0, 0, 0);
        end

        // Mixed traffic with idle, same-cycle and ignored busy restocks.
        busy_rs = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int amt;
            wait_ready();
            repeat ($urandom_range(0, 2)) begin
                if ($urandom_range(0, 2) == 0) begin
                    int a, b, c;
                    a = $urandom_range(0, 8); b = $urandom_range(0, 8); c = $urandom_range(0, 8);
                    restock = 1'b1;
                    restock_quarters = CNT_W'(a); restock_dimes = CNT_W'(b); restock_nickels = CNT_W'(c);
                    mq = sat(mq, a); md = sat(md, b); mn = sat(mn, c);
                end
                @(posedge clk); #1;
                restock = 1'b0;
            end
            case ($urandom_range(0, 3))
                0:       amt = 5 * $urandom_range(0, 51);
                1:       amt = $urandom_range(0, 30);
                default: amt = $urandom_range(0, 255);
            endcase
            if ($urandom_range(0, 3) == 0)
                do_request(amt, 1, $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40));
            else
                do_request(amt, 0, 0, 0, 0);
        end
        busy_rs = 1'b0;
        wait_ready();
        repeat (2) @(posedge clk);
        check("queues_empty", coin_q.size() + res_q.size(), 0);

        // Reset mid-request after the first coin is acknowledged.
        #1;
        restock = 1'b1;
        restock_quarters = CNT_W'(10); restock_dimes = CNT_W'(10); restock_nickels = CNT_W'(10);
        mq = sat(mq, 10); md = sat(md, 10); mn = sat(mn, 10);
        do_request(75, 0, 0, 0, 0);
        begin
            bit got = 1'b0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                if (coin_valid && coin_ack) got = 1'b1;
            end
            if (!got) check("ack_timeout", 0, 1);
        end
        @(posedge clk); #1;
        mon_en = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_coin_valid", int'(coin_valid), 0);
        check("mid_rst_ready", int'(change_ready), 1);
        check("mid_rst_quarters", int'(quarter_cnt), INIT_N);
        check("mid_rst_dimes", int'(dime_cnt), INIT_N);
        check("mid_rst_nickels", int'(nickel_cnt), INIT_N);
        reset = 1'b0;
        coin_q.delete();
        res_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
